// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: signal bundle between the ID-stage pipeline control and
// the hazard/stall controller.
//   master : pipeline side, drives ID/EX/MEM/WB hazard inputs, receives controls
//   slave  : hazard_stall_unit
// Inputs : ID_Rn/Rm/Rd + use bits, ID_B_instr, Cond_true, EX/MEM/WB_Rd + RF
//          enables, EX_Load_Inst, mem_req, mem_ready
// Outputs: fwd_A/B/C, PC_enable, IFID_enable, IFID_flush, CU_nop, pipe_hold,
//          mem_timeout, state, stall_cnt, flush_cnt
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       ID_Rn;
    logic [3:0]       ID_Rm;
    logic [3:0]       ID_Rd;
    logic             ID_use_Rn;
    logic             ID_use_Rm;
    logic             ID_use_Rd;
    logic             ID_B_instr;
    logic             Cond_true;
    logic [3:0]       EX_Rd;
    logic [3:0]       MEM_Rd;
    logic [3:0]       WB_Rd;
    logic             EX_RF_enable;
    logic             MEM_RF_enable;
    logic             WB_RF_enable;
    logic             EX_Load_Inst;
    logic             mem_req;
    logic             mem_ready;
    logic [1:0]       fwd_A;
    logic [1:0]       fwd_B;
    logic [1:0]       fwd_C;
    logic             PC_enable;
    logic             IFID_enable;
    logic             IFID_flush;
    logic             CU_nop;
    logic             pipe_hold;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_B_instr, Cond_true, EX_Rd, MEM_Rd, WB_Rd,
               EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_Load_Inst,
               mem_req, mem_ready,
        input  fwd_A, fwd_B, fwd_C, PC_enable, IFID_enable, IFID_flush,
               CU_nop, pipe_hold, mem_timeout, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_B_instr, Cond_true, EX_Rd, MEM_Rd, WB_Rd,
               EX_RF_enable, MEM_RF_enable, WB_RF_enable, EX_Load_Inst,
               mem_req, mem_ready,
        output fwd_A, fwd_B, fwd_C, PC_enable, IFID_enable, IFID_flush,
               CU_nop, pipe_hold, mem_timeout, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: hazard and stall controller for the 5-stage ARM pipeline.
// Produces operand forwarding selects, load-use bubbles, IF/ID flushes on taken
// branches and whole-pipe holds during data-memory waits (with timeout).
// Ports:
//   CLK  - pipeline clock, rising edge
//   CLR  - asynchronous active-low reset
//   bus  - hazard_stall_unit_if.slave (hazard inputs, control outputs)
// Parameters: WAIT_MAX (memory-wait cycles before timeout, 1..255), CNT_W.
// Optional feature macro: HAZARD_STATS_EN enables the saturating stall/flush
// statistics counters; when undefined both counters read 0.
module hazard_stall_unit #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                 CLK,
    input  logic                 CLR,
    hazard_stall_unit_if.slave   bus
);

    localparam int unsigned REG_W  = 4;
    localparam int unsigned WCNT_W = 8;
    localparam logic [REG_W-1:0]  PC_REG     = REG_W'(15);
    localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(WAIT_MAX);

    typedef enum logic [1:0] {
        ST_RUN        = 2'b00,
        ST_MEM_WAIT   = 2'b01,
        ST_LOAD_STALL = 2'b10,
        ST_ERROR      = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;

    logic load_use_c;
    logic branch_c;
    logic hold_req_c;
    logic hold_c;
    logic pc_en_c;
    logic ifid_en_c;
    logic flush_c;
    logic nop_c;

    // Youngest producing stage wins; R15 and unused fields always read the RF.
    function automatic logic [1:0] fwd_sel(
        input logic             use_f,
        input logic [REG_W-1:0] src,
        input logic             ex_en,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_en,
        input logic [REG_W-1:0] mem_rd,
        input logic             wb_en,
        input logic [REG_W-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_f && src != PC_REG) begin
            if (ex_en && ex_rd == src) begin
                sel = 2'b01;
            end else if (mem_en && mem_rd == src) begin
                sel = 2'b10;
            end else if (wb_en && wb_rd == src) begin
                sel = 2'b11;
            end
        end
        return sel;
    endfunction

    // Load in EX whose destination feeds a used source of the ID instruction.
    always_comb begin
        load_use_c = bus.EX_Load_Inst && bus.EX_RF_enable && (bus.EX_Rd != PC_REG) &&
                     ((bus.ID_use_Rn && bus.ID_Rn == bus.EX_Rd) ||
                      (bus.ID_use_Rm && bus.ID_Rm == bus.EX_Rd) ||
                      (bus.ID_use_Rd && bus.ID_Rd == bus.EX_Rd));
        branch_c   = bus.ID_B_instr && bus.Cond_true;
        hold_req_c = bus.mem_req && !bus.mem_ready;
    end

    // State register and sticky timeout flag.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state and pipeline controls; priority ERROR > hold > load-use > branch.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        hold_c    = 1'b0;
        pc_en_c   = 1'b1;
        ifid_en_c = 1'b1;
        flush_c   = 1'b0;
        nop_c     = 1'b0;

        if (state_q == ST_ERROR) begin
            hold_c    = 1'b1;
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
        end else begin
            // Memory hold is only honoured in RUN and MEM_WAIT.
            hold_c = hold_req_c && (state_q != ST_LOAD_STALL);
            if (hold_c) begin
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
            end else if (load_use_c) begin
                pc_en_c   = 1'b0;
                ifid_en_c = 1'b0;
                nop_c     = 1'b1;
            end else if (branch_c) begin
                flush_c   = 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (hold_c) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = WCNT_W'(1);
                end else if (load_use_c) begin
                    state_d = ST_LOAD_STALL;
                end
            end
            ST_MEM_WAIT: begin
                if (hold_c) begin
                    if (wait_q == WAIT_LIMIT) begin
                        state_d   = ST_ERROR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WCNT_W'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                    wait_d  = '0;
                end
            end
            ST_LOAD_STALL: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // Forwarding selects are suppressed while in ERROR.
    assign bus.fwd_A = (state_q == ST_ERROR) ? 2'b00 :
        fwd_sel(bus.ID_use_Rn, bus.ID_Rn, bus.EX_RF_enable, bus.EX_Rd,
                bus.MEM_RF_enable, bus.MEM_Rd, bus.WB_RF_enable, bus.WB_Rd);
    assign bus.fwd_B = (state_q == ST_ERROR) ? 2'b00 :
        fwd_sel(bus.ID_use_Rm, bus.ID_Rm, bus.EX_RF_enable, bus.EX_Rd,
                bus.MEM_RF_enable, bus.MEM_Rd, bus.WB_RF_enable, bus.WB_Rd);
    assign bus.fwd_C = (state_q == ST_ERROR) ? 2'b00 :
        fwd_sel(bus.ID_use_Rd, bus.ID_Rd, bus.EX_RF_enable, bus.EX_Rd,
                bus.MEM_RF_enable, bus.MEM_Rd, bus.WB_RF_enable, bus.WB_Rd);

    assign bus.PC_enable   = pc_en_c;
    assign bus.IFID_enable = ifid_en_c;
    assign bus.IFID_flush  = flush_c;
    assign bus.CU_nop      = nop_c;
    assign bus.pipe_hold   = hold_c;
    assign bus.mem_timeout = timeout_q;
    assign bus.state       = state_q;

`ifdef HAZARD_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters of PC-stalled cycles and IF/ID flushes.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en_c && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_c && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = CNT_W'(0);
    assign bus.flush_cnt = CNT_W'(0);
`endif

endmodule
